// File: rtl/lvds_clk_pkg.sv
// Shared types and constants for the LVDS clock sequencer.
// Holds the state encoding (also exported on the debug port), the
// loss counter width and the per-state output decode.
package lvds_clk_pkg;

    // Width of the debug state encoding
    localparam int STATE_W = 3;

    // Width of the saturating lock-loss counter
    localparam int LOSS_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF       = 3'd0,
        ST_PLL_RESET = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_CLK_ON    = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    // Larger of two integers, used to size the shared counter
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Moore output decode: {pll_rst, pll_stdby, enclkop, lvds_rst_n, ready, fault}
    function automatic logic [5:0] state_outputs(input state_t s);
        logic [5:0] v;
        case (s)
            ST_OFF:       v = 6'b110000;
            ST_PLL_RESET: v = 6'b100000;
            ST_WAIT_LOCK: v = 6'b000000;
            ST_STABLE:    v = 6'b000000;
            ST_CLK_ON:    v = 6'b001000;
            ST_RUN:       v = 6'b001110;
            ST_FAULT:     v = 6'b100001;
            default:      v = 6'b110000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/lvds_clk_sequencer_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the
// reference clock domain. Resets to "unlocked".
module lvds_clk_sequencer_lock_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/lvds_clk_sequencer.sv
// Power-up / recovery sequencer for the ECP5 EHXPLLL producing the LVDS
// bit clock. Runs entirely on the 48 MHz reference clock. One shared
// counter times every state; it is cleared on each state entry so it
// never wraps. All outputs are registered decodes of the next state, so
// they change on the same edge the state register does.
module lvds_clk_sequencer
    import lvds_clk_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4800,
    parameter int STABLE_CYCLES = 1024,
    parameter int ENA_DLY       = 8,
    parameter int LOSS_FILTER   = 4,
    parameter int MAX_RETRIES   = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_pll_lock,
    output logic              o_pll_rst,
    output logic              o_pll_stdby,
    output logic              o_pll_enclkop,
    output logic              o_lvds_rst_n,
    output logic              o_ready,
    output logic              o_fault,
    output logic [STATE_W-1:0] o_state,
    output logic [LOSS_W-1:0]  o_loss_count
);

    localparam int CNT_MAX = max_of(max_of(max_of(RST_CYCLES, LOCK_TIMEOUT),
                                           max_of(STABLE_CYCLES, ENA_DLY)),
                                    LOSS_FILTER);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic               w_lock_s;
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RTY_W-1:0]   r_retry;
    logic [LOSS_W-1:0]  r_loss;
    logic [5:0]         r_outs;

    state_t             w_nxt_state;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic [RTY_W-1:0]   w_nxt_retry;
    logic [LOSS_W-1:0]  w_nxt_loss;

    lvds_clk_sequencer_lock_sync u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pll_lock),
        .o_q     (w_lock_s)
    );

    // Next-state, counter, retry and loss-count computation
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_retry = r_retry;
        w_nxt_loss  = r_loss;
        if (!i_enable) begin
            // Dropping the request wins over everything; loss history is kept
            w_nxt_state = ST_OFF;
            w_nxt_cnt   = {CNT_W{1'b0}};
            w_nxt_retry = {RTY_W{1'b0}};
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_nxt_state = ST_PLL_RESET;
                    w_nxt_cnt   = {CNT_W{1'b0}};
                end
                ST_PLL_RESET: begin
                    if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        w_nxt_state = ST_WAIT_LOCK;
                        w_nxt_cnt   = {CNT_W{1'b0}};
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_nxt_state = ST_STABLE;
                        w_nxt_cnt   = {CNT_W{1'b0}};
                    end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        w_nxt_cnt = {CNT_W{1'b0}};
                        if (r_retry == RTY_W'(MAX_RETRIES)) begin
                            w_nxt_state = ST_FAULT;
                        end else begin
                            w_nxt_state = ST_PLL_RESET;
                            w_nxt_retry = r_retry + RTY_W'(1);
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!w_lock_s) begin
                        // Any glitch restarts the wait with a fresh timeout
                        w_nxt_state = ST_WAIT_LOCK;
                        w_nxt_cnt   = {CNT_W{1'b0}};
                    end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        w_nxt_state = ST_CLK_ON;
                        w_nxt_cnt   = {CNT_W{1'b0}};
                        w_nxt_retry = {RTY_W{1'b0}};
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_CLK_ON: begin
                    // Lock is deliberately ignored here; RUN catches a drop
                    if (r_cnt == CNT_W'(ENA_DLY - 1)) begin
                        w_nxt_state = ST_RUN;
                        w_nxt_cnt   = {CNT_W{1'b0}};
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // Counter acts as the loss filter here
                    if (w_lock_s) begin
                        w_nxt_cnt = {CNT_W{1'b0}};
                    end else if (r_cnt == CNT_W'(LOSS_FILTER - 1)) begin
                        w_nxt_state = ST_PLL_RESET;
                        w_nxt_cnt   = {CNT_W{1'b0}};
                        if (r_loss != {LOSS_W{1'b1}}) begin
                            w_nxt_loss = r_loss + LOSS_W'(1);
                        end else begin
                            w_nxt_loss = r_loss;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    w_nxt_cnt = {CNT_W{1'b0}};
                end
                default: begin
                    w_nxt_state = ST_OFF;
                    w_nxt_cnt   = {CNT_W{1'b0}};
                    w_nxt_retry = {RTY_W{1'b0}};
                end
            endcase
        end
    end

    // State, counters and registered Moore outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_OFF;
            r_cnt   <= {CNT_W{1'b0}};
            r_retry <= {RTY_W{1'b0}};
            r_loss  <= {LOSS_W{1'b0}};
            r_outs  <= state_outputs(ST_OFF);
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_retry <= w_nxt_retry;
            r_loss  <= w_nxt_loss;
            r_outs  <= state_outputs(w_nxt_state);
        end
    end

    assign o_pll_rst     = r_outs[5];
    assign o_pll_stdby   = r_outs[4];
    assign o_pll_enclkop = r_outs[3];
    assign o_lvds_rst_n  = r_outs[2];
    assign o_ready       = r_outs[1];
    assign o_fault       = r_outs[0];
    assign o_state       = r_state;
    assign o_loss_count  = r_loss;

endmodule

// File: tb/tb_lvds_clk_sequencer.sv
// Directed bench for lvds_clk_sequencer with shortened timing parameters.
// A table of {enable, lock, cycles to advance, expected state, expected
// loss count} rows drives the main sequence; expected output pins come
// from the per-state output table. Hand-written sequences cover the
// bounded bring-up and asynchronous reset.
module tb_lvds_clk_sequencer;

    localparam logic [2:0] S_OFF = 3'd0, S_PLL = 3'd1, S_WAIT = 3'd2, S_STAB = 3'd3,
                           S_CLKON = 3'd4, S_RUN = 3'd5, S_FAULT = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       lock = 1'b0;
    logic       pll_rst, pll_stdby, pll_enclkop, lvds_rst_n, ready, fault;
    logic [2:0] state;
    logic [7:0] loss_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       en;
        logic       lock;
        int         n;
        logic [2:0] st;
        logic [7:0] loss;
    } vec_t;

    vec_t vecs[$];

    lvds_clk_sequencer #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(16),
        .ENA_DLY(8), .LOSS_FILTER(3), .MAX_RETRIES(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pll_lock(lock),
        .o_pll_rst(pll_rst), .o_pll_stdby(pll_stdby), .o_pll_enclkop(pll_enclkop),
        .o_lvds_rst_n(lvds_rst_n), .o_ready(ready), .o_fault(fault),
        .o_state(state), .o_loss_count(loss_count)
    );

    always #10 clk = ~clk;

    // Expected {rst, stdby, enclkop, lvds_rst_n, ready, fault} per state
    function automatic logic [5:0] exp_pins(input logic [2:0] s);
        case (s)
            S_OFF:   return 6'b110000;
            S_PLL:   return 6'b100000;
            S_WAIT:  return 6'b000000;
            S_STAB:  return 6'b000000;
            S_CLKON: return 6'b001000;
            S_RUN:   return 6'b001110;
            S_FAULT: return 6'b100001;
            default: return 6'b111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic l, input int n,
                       input logic [2:0] st, input logic [7:0] loss);
        vec_t v;
        v.en = e; v.lock = l; v.n = n; v.st = st; v.loss = loss;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [7:0] loss);
        chk({tag, " state"}, 32'(state), 32'(st));
        chk({tag, " pins"}, 32'({pll_rst, pll_stdby, pll_enclkop, lvds_rst_n, ready, fault}),
            32'(exp_pins(st)));
        chk({tag, " loss"}, 32'(loss_count), 32'(loss));
    endtask

    initial begin
        // Nominal bring-up
        add(1,0,1,S_PLL,0);   add(1,0,3,S_PLL,0);   add(1,0,1,S_WAIT,0);
        add(1,0,9,S_WAIT,0);  add(1,1,2,S_WAIT,0);  add(1,1,1,S_STAB,0);
        add(1,1,15,S_STAB,0); add(1,1,1,S_CLKON,0); add(1,1,7,S_CLKON,0);
        add(1,1,1,S_RUN,0);
        // Loss in RUN: 2-cycle dip ignored, 3-cycle dip re-sequences
        add(1,0,2,S_RUN,0);   add(1,1,4,S_RUN,0);   add(1,0,3,S_RUN,0);
        add(1,1,2,S_PLL,1);   add(1,1,3,S_PLL,1);   add(1,1,1,S_WAIT,1);
        add(1,1,1,S_STAB,1);  add(1,1,16,S_CLKON,1); add(1,1,8,S_RUN,1);
        // Enable dropped mid-RUN, then mid-STABLE
        add(0,1,1,S_OFF,1);   add(1,1,1,S_PLL,1);   add(1,1,4,S_WAIT,1);
        add(1,1,1,S_STAB,1);  add(1,1,5,S_STAB,1);  add(0,1,1,S_OFF,1);
        // Lock chatter in STABLE
        add(1,0,1,S_PLL,1);   add(1,0,4,S_WAIT,1);  add(1,1,3,S_STAB,1);
        add(1,1,7,S_STAB,1);  add(1,0,1,S_STAB,1);  add(1,1,1,S_STAB,1);
        add(1,1,1,S_WAIT,1);  add(1,1,1,S_STAB,1);  add(1,1,15,S_STAB,1);
        add(1,1,1,S_CLKON,1);
        // Lock never arrives: three attempts then FAULT
        add(0,0,1,S_OFF,1);   add(1,0,1,S_PLL,1);   add(1,0,3,S_PLL,1);
        add(1,0,1,S_WAIT,1);  add(1,0,31,S_WAIT,1); add(1,0,1,S_PLL,1);
        add(1,0,3,S_PLL,1);   add(1,0,1,S_WAIT,1);  add(1,0,31,S_WAIT,1);
        add(1,0,1,S_PLL,1);   add(1,0,4,S_WAIT,1);  add(1,0,31,S_WAIT,1);
        add(1,0,1,S_FAULT,1); add(1,0,5,S_FAULT,1); add(0,0,1,S_OFF,1);
        // Re-enable after FAULT: retry count starts from zero again
        add(1,0,1,S_PLL,1);   add(1,0,4,S_WAIT,1);  add(1,0,32,S_PLL,1);
        add(1,0,4,S_WAIT,1);  add(1,0,32,S_PLL,1);  add(1,0,4,S_WAIT,1);
        add(1,0,31,S_WAIT,1); add(1,0,1,S_FAULT,1); add(0,0,1,S_OFF,1);

        // Reset state while rst_n is held low
        step(2);
        check_all("reset", S_OFF, 8'd0);
        #4 rst_n = 1'b1;
        step(2);
        check_all("idle", S_OFF, 8'd0);

        foreach (vecs[i]) begin
            en   = vecs[i].en;
            lock = vecs[i].lock;
            step(vecs[i].n);
            check_all($sformatf("row%0d", i), vecs[i].st, vecs[i].loss);
        end

        // Bounded bring-up to RUN
        en = 1'b1;
        lock = 1'b1;
        for (int k = 0; k < 200 && !ready; k++) step(1);
        chk("bringup ready", 32'(ready), 32'd1);
        check_all("bringup run", S_RUN, 8'd1);

        // Asynchronous reset mid-cycle in RUN
        #4 rst_n = 1'b0;
        #1;
        check_all("async reset", S_OFF, 8'd0);
        step(1);
        check_all("reset held", S_OFF, 8'd0);
        #4 rst_n = 1'b1;
        step(1);
        check_all("after reset", S_PLL, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
